mult_hilo_unit: RTL and testbench
=================================

# mult_hilo_unit

Multi-cycle multiply/accumulate unit with architectural HI/LO registers, sitting directly downstream of the ALU control decode in the execute stage. It consumes the 5-bit ALU control code for MULT, MULTU, MUL, MADD and MSUB plus the two register operands. It computes the 64-bit product iteratively, then updates HI/LO or returns a 32-bit MUL result. A Busy/Done handshake lets the pipeline controller stall while a product is in flight.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- Clk  input  1  pipeline clock; all state changes on rising edge.
- Rst  input  1  synchronous, active-low reset.
- Start  input  1  request; sampled only when the unit is idle or in DONE.
- ALUControl  input  5  operation code: MULT=00011, MULTU=00100, MUL=10011, MADD=10100, MSUB=10101.
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- Flush  input  1  abort the in-flight operation.
- Busy  output  1  operation in progress; the pipeline must stall.
- Done  output  1  one-cycle pulse: the result is valid.
- MulResult  output  WIDTH  low word of the signed product for MUL; held until the next MUL completes.
- Hi  output  WIDTH  architectural HI register.
- Lo  output  WIDTH  architectural LO register.

## Operation
- States: IDLE, CALC, ACC, DONE.
- Accepted request:
  - Start=1 in IDLE or DONE with ALUControl in the five codes above.
  - Latches A, B, the opcode and the signed flag (all codes except MULTU are signed).
  - Enters CALC with a bit counter of 0.
- Ignored request: Start with any other code is ignored; the state is unchanged and Done is not pulsed.
- Signed operands: the magnitudes of A and B are multiplied unsigned. The 64-bit product is negated in ACC when the operand signs differ.
- CALC (shift-add):
  - Each cycle, the multiplier LSB conditionally adds the shifted multiplicand to the 64-bit partial product.
  - The counter runs 0..WIDTH-1; CALC then goes to ACC.
- ACC, by opcode:
  - MULT/MULTU: {Hi,Lo} <= product.
  - MADD: {Hi,Lo} <= {Hi,Lo} + product, 64-bit, wraps modulo 2^64.
  - MSUB: {Hi,Lo} <= {Hi,Lo} - product, 64-bit, wraps modulo 2^64.
  - MUL: MulResult <= product[WIDTH-1:0]; Hi/Lo unchanged.
  - Then go to DONE.
- DONE: Done=1 for exactly one cycle. The next state is CALC if a valid Start is present that cycle, otherwise IDLE.
- Busy = 1 in CALC and ACC; 0 in IDLE and DONE.
- Start while Busy is ignored; the operands of the in-flight operation are not disturbed.
- Flush=1 in CALC or ACC:
  - Returns to IDLE next cycle, no Done.
  - Hi/Lo/MulResult are unchanged (ACC writes are suppressed).
  - Flush in IDLE/DONE has no effect, and Flush has priority over Start in the same cycle.
- Reset (Rst=0, any state, including mid-CALC):
  - State=IDLE, counter=0, Busy=0, Done=0, Hi=0, Lo=0, MulResult=0.
  - Start and Flush are ignored while Rst=0.

## Timing
- Start accepted at edge k. Busy=1 from k+1 through k+WIDTH+1 (CALC covers edges k+1..k+WIDTH, ACC covers edge k+WIDTH+1).
- Hi/Lo/MulResult update at edge k+WIDTH+1. Done=1 and the new values are visible in the cycle after that edge. Latency is WIDTH+2 cycles from Start to Done, i.e. 34 cycles for WIDTH=32.
- Back-to-back: a Start in the DONE cycle is accepted. The second operation's MADD/MSUB sees the first's Hi/Lo.
- Outputs are registered; there is no combinational path from inputs to Busy/Done.

## Configuration
- MULT_HILO_FAST_EN:
  - Defined: CALC lasts a single cycle and computes the full product with one WIDTH x WIDTH multiplier. Latency is 3 cycles (Busy for 2 cycles, then Done).
  - Undefined: the iterative shift-add path above with WIDTH+2 latency.
  - All state names, handshake rules, Flush/reset behaviour and results are identical in both builds.

## Test plan
- Reset, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Done at cycle 34, Hi=0xFFFFFFFE, Lo=0x00000001, Busy high for exactly 33 cycles.
- MULT A=0xFFFFFFFE (-2) B=3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; then MUL A=0x00010000 B=0x00010003 -> MulResult=0x00030000, Hi/Lo unchanged.
- MULT A=0 B=10 then back-to-back MADD A=4 B=5 (Start in DONE cycle) -> Hi=0, Lo=20; then MSUB A=5 B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFB (20-25 wraps).
- MULTU A=7 B=9 with Flush pulsed at cycle 10 -> no Done, Busy=0 next cycle, Hi/Lo keep their prior values; Start during Busy with different operands -> ignored, original result produced.
- Rst=0 asserted mid-CALC after Hi/Lo=0x12345678/0x9ABCDEF0 -> next edge Busy=0, Done=0, Hi=Lo=MulResult=0; Start with ALUControl=00000 -> stays IDLE, no Done.
- With MULT_HILO_FAST_EN defined: repeat the first scenario -> Done at cycle 3 with identical values.

Source files
------------

// File: rtl/mult_hilo_unit.sv
// Multi-cycle multiply/accumulate unit with architectural HI/LO registers and a Busy/Done handshake.
// Define MULT_HILO_FAST_EN for the single-cycle multiplier variant; the default is iterative shift-add.
module mult_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [4:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] MulResult,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [4:0] OP_MULT  = 5'b00011;
    localparam logic [4:0] OP_MULTU = 5'b00100;
    localparam logic [4:0] OP_MUL   = 5'b10011;
    localparam logic [4:0] OP_MADD  = 5'b10100;
    localparam logic [4:0] OP_MSUB  = 5'b10101;

`ifdef MULT_HILO_FAST_EN
    localparam int MCW = WIDTH;
`else
    // The multiplicand is shifted left once per CALC cycle, so it needs the full product width.
    localparam int MCW = 2 * WIDTH;
    localparam int CW  = $clog2(WIDTH);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_reg,  state_next;
    logic [4:0]           op_reg,     op_next;
    logic                 neg_reg,    neg_next;
    logic [MCW-1:0]       mcand_reg,  mcand_next;
    logic [WIDTH-1:0]     mplier_reg, mplier_next;
    logic [2*WIDTH-1:0]   prod_reg,   prod_next;
    logic [WIDTH-1:0]     hi_reg,     hi_next;
    logic [WIDTH-1:0]     lo_reg,     lo_next;
    logic [WIDTH-1:0]     mul_reg,    mul_next;
`ifndef MULT_HILO_FAST_EN
    logic [CW-1:0]        cnt_reg,    cnt_next;
`endif

    logic                 op_valid;
    logic                 op_signed;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   prod_final;
    logic [2*WIDTH-1:0]   hilo_cur;

    assign op_valid  = (ALUControl == OP_MULT) || (ALUControl == OP_MULTU) ||
                       (ALUControl == OP_MUL)  || (ALUControl == OP_MADD)  ||
                       (ALUControl == OP_MSUB);
    assign op_signed = (ALUControl != OP_MULTU);
    assign a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;
    // Magnitudes are multiplied unsigned; the sign is restored once, at accumulate time.
    assign prod_final = neg_reg ? -prod_reg : prod_reg;
    assign hilo_cur   = {hi_reg, lo_reg};

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        neg_next    = neg_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        prod_next   = prod_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        mul_next    = mul_reg;
`ifndef MULT_HILO_FAST_EN
        cnt_next    = cnt_reg;
`endif
        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (Start && op_valid) begin
                    state_next  = CALC;
                    op_next     = ALUControl;
                    neg_next    = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                    mplier_next = b_mag;
                    prod_next   = '0;
`ifdef MULT_HILO_FAST_EN
                    mcand_next  = a_mag;
`else
                    mcand_next  = {{WIDTH{1'b0}}, a_mag};
                    cnt_next    = '0;
`endif
                end
            end
            CALC: begin
                if (Flush) begin
                    state_next = IDLE;
                end else begin
`ifdef MULT_HILO_FAST_EN
                    prod_next  = {{WIDTH{1'b0}}, mcand_reg} * {{WIDTH{1'b0}}, mplier_reg};
                    state_next = ACC;
`else
                    if (mplier_reg[0]) begin
                        prod_next = prod_reg + mcand_reg;
                    end
                    mcand_next  = mcand_reg << 1;
                    mplier_next = mplier_reg >> 1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        state_next = ACC;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
`endif
                end
            end
            ACC: begin
                if (Flush) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                    case (op_reg)
                        OP_MULT, OP_MULTU: {hi_next, lo_next} = prod_final;
                        OP_MADD:           {hi_next, lo_next} = hilo_cur + prod_final;
                        OP_MSUB:           {hi_next, lo_next} = hilo_cur - prod_final;
                        OP_MUL:            mul_next = prod_final[WIDTH-1:0];
                        default:           ;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            mul_reg    <= '0;
`ifndef MULT_HILO_FAST_EN
            cnt_reg    <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            neg_reg    <= neg_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            prod_reg   <= prod_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            mul_reg    <= mul_next;
`ifndef MULT_HILO_FAST_EN
            cnt_reg    <= cnt_next;
`endif
        end
    end

    // Handshake outputs decode the state register only, so inputs never reach them combinationally.
    assign Busy      = (state_reg == CALC) || (state_reg == ACC);
    assign Done      = (state_reg == DONE);
    assign Hi        = hi_reg;
    assign Lo        = lo_reg;
    assign MulResult = mul_reg;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: vector table for results, hand sequences for handshake corners.
// Honours MULT_HILO_FAST_EN for the expected latency.
module tb_mult_hilo_unit;

    localparam logic [4:0] OP_MULT  = 5'b00011;
    localparam logic [4:0] OP_MULTU = 5'b00100;
    localparam logic [4:0] OP_MUL   = 5'b10011;
    localparam logic [4:0] OP_MADD  = 5'b10100;
    localparam logic [4:0] OP_MSUB  = 5'b10101;

`ifdef MULT_HILO_FAST_EN
    localparam int EXP_LAT  = 3;
    localparam int EXP_BUSY = 2;
    localparam int FLUSH_AT = 1;
    localparam int ACC_AT   = 2;
`else
    localparam int EXP_LAT  = 34;
    localparam int EXP_BUSY = 33;
    localparam int FLUSH_AT = 9;
    localparam int ACC_AT   = 33;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [4:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic [31:0] MulResult;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int total = 0;
    int bad   = 0;

    mult_hilo_unit #(.WIDTH(32)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .Flush      (Flush),
        .Busy       (Busy),
        .Done       (Done),
        .MulResult  (MulResult),
        .Hi         (Hi),
        .Lo         (Lo)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] mul;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at the first negedge after the accepting edge; returns at the Done sample or on timeout.
    task automatic wait_done(input string name, output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (!Done && lat < 200) begin
            if (Busy) busy_cnt++;
            @(negedge Clk);
            lat++;
        end
        check({name, "_done_seen"}, {31'd0, Done}, 32'd1);
    endtask

    task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output int busy_cnt);
        @(negedge Clk);
        Start = 1'b1; ALUControl = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0; ALUControl = 5'd0; A = 32'hDEADBEEF; B = 32'h0BADF00D;
        wait_done(name, lat, busy_cnt);
        $display("txn %s op=%b a=%h b=%h lat=%0d -> hi=%h lo=%h mul=%h",
                 name, op, a, b, lat, Hi, Lo, MulResult);
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;

        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000000};
        vecs[1] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00000000};
        vecs[2] = '{OP_MUL,   32'h00010000, 32'h00010003, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00030000};
        vecs[3] = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 32'h00030000};
        vecs[4] = '{OP_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 32'h00030000};
        vecs[5] = '{OP_MADD,  32'h00010000, 32'h00010000, 32'h00000000, 32'h00000000, 32'h00030000};
        vecs[6] = '{OP_MADD,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'h00030000};
        vecs[7] = '{OP_MSUB,  32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFDB, 32'h00030000};
        vecs[8] = '{OP_MUL,   32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFDB, 32'h00000000};
        vecs[9] = '{OP_MUL,   32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFDB, 32'hFFFFFFFB};

        Rst = 1'b0; Start = 1'b0; Flush = 1'b0; ALUControl = 5'd0; A = '0; B = '0;
        repeat (3) @(negedge Clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_hi", Hi, 32'd0);
        check("rst_lo", Lo, 32'd0);
        check("rst_mul", MulResult, 32'd0);
        Rst = 1'b1;

        // Result table, sequential (accumulating ops depend on earlier rows).
        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_cnt);
            if (i == 0) begin
                check("vec0_latency", lat, EXP_LAT);
                check("vec0_busy_cycles", busy_cnt, EXP_BUSY);
            end
            check($sformatf("vec%0d_hi", i), Hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), Lo, vecs[i].lo);
            check($sformatf("vec%0d_mul", i), MulResult, vecs[i].mul);
            @(negedge Clk);
            check($sformatf("vec%0d_done_pulse", i), {31'd0, Done}, 32'd0);
        end

        // Back-to-back: MADD started in the DONE cycle of MULT sees MULT's HI/LO.
        do_op("b2b_mult", OP_MULT, 32'd0, 32'd10, lat, busy_cnt);
        check("b2b_mult_hi", Hi, 32'd0);
        check("b2b_mult_lo", Lo, 32'd0);
        Start = 1'b1; ALUControl = OP_MADD; A = 32'd4; B = 32'd5;
        @(negedge Clk);
        Start = 1'b0; ALUControl = 5'd0;
        check("b2b_accept_busy", {31'd0, Busy}, 32'd1);
        check("b2b_accept_done", {31'd0, Done}, 32'd0);
        wait_done("b2b_madd", lat, busy_cnt);
        $display("txn b2b_madd lat=%0d -> hi=%h lo=%h", lat, Hi, Lo);
        check("b2b_madd_lat", lat, EXP_LAT);
        check("b2b_madd_hi", Hi, 32'd0);
        check("b2b_madd_lo", Lo, 32'd20);
        do_op("msub", OP_MSUB, 32'd5, 32'd5, lat, busy_cnt);
        check("msub_hi", Hi, 32'hFFFFFFFF);
        check("msub_lo", Lo, 32'hFFFFFFFB);

        // Flush during CALC.
        @(negedge Clk);
        Start = 1'b1; ALUControl = OP_MULTU; A = 32'd7; B = 32'd9;
        @(negedge Clk);
        Start = 1'b0;
        repeat (FLUSH_AT - 1) @(negedge Clk);
        Flush = 1'b1; Start = 1'b1;
        @(negedge Clk);
        Flush = 1'b0; Start = 1'b0;
        check("flush_calc_busy", {31'd0, Busy}, 32'd0);
        check("flush_calc_done", {31'd0, Done}, 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) done_cnt++;
        end
        $display("txn flush_calc -> hi=%h lo=%h done_pulses=%0d", Hi, Lo, done_cnt);
        check("flush_calc_no_done", done_cnt, 0);
        check("flush_calc_hi", Hi, 32'hFFFFFFFF);
        check("flush_calc_lo", Lo, 32'hFFFFFFFB);

        // Flush during ACC suppresses the MUL write.
        Start = 1'b1; ALUControl = OP_MUL; A = 32'd3; B = 32'd3;
        @(negedge Clk);
        Start = 1'b0;
        repeat (ACC_AT - 1) @(negedge Clk);
        check("flush_acc_busy_before", {31'd0, Busy}, 32'd1);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush_acc_busy", {31'd0, Busy}, 32'd0);
        check("flush_acc_done", {31'd0, Done}, 32'd0);
        $display("txn flush_acc -> mul=%h", MulResult);
        check("flush_acc_mul", MulResult, 32'hFFFFFFFB);

        // Start while busy is ignored; original operands complete.
        @(negedge Clk);
        Start = 1'b1; ALUControl = OP_MULTU; A = 32'd7; B = 32'd9;
        @(negedge Clk);
        ALUControl = OP_MULTU; A = 32'd100; B = 32'd100;
        @(negedge Clk);
        Start = 1'b0;
        wait_done("busy_start", lat, busy_cnt);
        $display("txn busy_start -> hi=%h lo=%h", Hi, Lo);
        check("busy_start_hi", Hi, 32'd0);
        check("busy_start_lo", Lo, 32'd63);
        @(negedge Clk);
        check("busy_start_idle", {31'd0, Busy}, 32'd0);

        // Reset mid-CALC clears architectural state.
        do_op("setup_hi", OP_MULTU, 32'h2468ACF0, 32'h80000000, lat, busy_cnt);
        do_op("setup_lo", OP_MADD, 32'h4D5E6F78, 32'd2, lat, busy_cnt);
        check("setup_hi", Hi, 32'h12345678);
        check("setup_lo", Lo, 32'h9ABCDEF0);
        @(negedge Clk);
        Start = 1'b1; ALUControl = OP_MULTU; A = 32'd7; B = 32'd9;
        @(negedge Clk);
        repeat (1) @(negedge Clk);
        Rst = 1'b0; Flush = 1'b1;
        @(negedge Clk);
        check("rst_mid_busy", {31'd0, Busy}, 32'd0);
        check("rst_mid_done", {31'd0, Done}, 32'd0);
        check("rst_mid_hi", Hi, 32'd0);
        check("rst_mid_lo", Lo, 32'd0);
        check("rst_mid_mul", MulResult, 32'd0);
        @(negedge Clk);
        check("rst_hold_busy", {31'd0, Busy}, 32'd0);
        Rst = 1'b1; Flush = 1'b0; ALUControl = 5'b00000; A = 32'd3; B = 32'd4;
        @(negedge Clk);
        Start = 1'b0;
        check("bad_op_busy", {31'd0, Busy}, 32'd0);
        done_cnt = 0;
        repeat (5) begin
            @(negedge Clk);
            if (Done || Busy) done_cnt++;
        end
        $display("txn bad_op -> busy_or_done_cycles=%0d", done_cnt);
        check("bad_op_no_activity", done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
